sfr_apb_shadow_regs: RTL and testbench

APB responder holding the video-timing, filter-mode and blur-weight SFRs for the image pipeline.
- APB writes land in a staging bank.
- The active bank, which drives the datapath outputs, loads from staging on each VSYNC rising edge. Mid-frame writes therefore never disturb the current frame.
- Sits between the APB interconnect and the timing generator / blur filter.

---
 rtl/sfr_pkg.sv | 91 +++++++++
 rtl/sfr_apb_wait.sv | 35 +++
 rtl/sfr_apb_shadow_regs.sv | 139 +++++++++++++
 tb/tb_sfr_apb_shadow_regs.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/sfr_pkg.sv
// sfr_pkg: register map, bank layout and write/read decode helpers for sfr_apb_shadow_regs.
`default_nettype none

package sfr_pkg;

  localparam int SFR_TIM_W = 16;
  localparam int SFR_WGT_W = 4;

  localparam logic [7:0] SFR_VSW_OFS    = 8'h00;
  localparam logic [7:0] SFR_VBP_OFS    = 8'h04;
  localparam logic [7:0] SFR_VACT_OFS   = 8'h08;
  localparam logic [7:0] SFR_VFP_OFS    = 8'h0C;
  localparam logic [7:0] SFR_HSW_OFS    = 8'h10;
  localparam logic [7:0] SFR_HBP_OFS    = 8'h14;
  localparam logic [7:0] SFR_HACT_OFS   = 8'h18;
  localparam logic [7:0] SFR_HFP_OFS    = 8'h1C;
  localparam logic [7:0] SFR_MODE_OFS   = 8'h20;
  localparam logic [7:0] SFR_W123_OFS   = 8'h24;
  localparam logic [7:0] SFR_W456_OFS   = 8'h28;
  localparam logic [7:0] SFR_W789_OFS   = 8'h2C;
  localparam logic [7:0] SFR_STATUS_OFS = 8'h30;
  localparam logic [7:0] SFR_CTRL_OFS   = 8'h34;

  typedef logic [SFR_TIM_W-1:0] sfr_tim_t;
  typedef logic [SFR_WGT_W-1:0] sfr_wgt_t;

  // w[0] is W1 ... w[8] is W9
  typedef struct packed {
    sfr_tim_t          vsw, vbp, vact, vfp;
    sfr_tim_t          hsw, hbp, hact, hfp;
    logic              blur_mode;
    logic              mirror_mode;
    logic              weight_wr_mode;
    sfr_wgt_t [8:0]    w;
  } sfr_bank_t;

  function automatic logic sfr_is_bank_ofs(input logic [7:0] ofs);
    return (ofs[1:0] == 2'b00) && (ofs <= SFR_W789_OFS);
  endfunction

  function automatic sfr_bank_t sfr_apply_write(input sfr_bank_t bank,
                                                input logic [7:0] ofs,
                                                input logic [31:0] data);
    sfr_bank_t b;
    b = bank;
    case (ofs)
      SFR_VSW_OFS:  b.vsw  = data[15:0];
      SFR_VBP_OFS:  b.vbp  = data[15:0];
      SFR_VACT_OFS: b.vact = data[15:0];
      SFR_VFP_OFS:  b.vfp  = data[15:0];
      SFR_HSW_OFS:  b.hsw  = data[15:0];
      SFR_HBP_OFS:  b.hbp  = data[15:0];
      SFR_HACT_OFS: b.hact = data[15:0];
      SFR_HFP_OFS:  b.hfp  = data[15:0];
      SFR_MODE_OFS: begin
        b.weight_wr_mode = data[0];
        b.mirror_mode    = data[1];
        b.blur_mode      = data[2];
      end
      SFR_W123_OFS: begin b.w[0] = data[3:0]; b.w[1] = data[7:4]; b.w[2] = data[11:8]; end
      SFR_W456_OFS: begin b.w[3] = data[3:0]; b.w[4] = data[7:4]; b.w[5] = data[11:8]; end
      SFR_W789_OFS: begin b.w[6] = data[3:0]; b.w[7] = data[7:4]; b.w[8] = data[11:8]; end
      default: ;
    endcase
    return b;
  endfunction

  function automatic logic [31:0] sfr_read_bank(input sfr_bank_t bank, input logic [7:0] ofs);
    logic [31:0] r;
    r = '0;
    case (ofs)
      SFR_VSW_OFS:  r = {16'h0, bank.vsw};
      SFR_VBP_OFS:  r = {16'h0, bank.vbp};
      SFR_VACT_OFS: r = {16'h0, bank.vact};
      SFR_VFP_OFS:  r = {16'h0, bank.vfp};
      SFR_HSW_OFS:  r = {16'h0, bank.hsw};
      SFR_HBP_OFS:  r = {16'h0, bank.hbp};
      SFR_HACT_OFS: r = {16'h0, bank.hact};
      SFR_HFP_OFS:  r = {16'h0, bank.hfp};
      SFR_MODE_OFS: r = {29'h0, bank.blur_mode, bank.mirror_mode, bank.weight_wr_mode};
      SFR_W123_OFS: r = {20'h0, bank.w[2], bank.w[1], bank.w[0]};
      SFR_W456_OFS: r = {20'h0, bank.w[5], bank.w[4], bank.w[3]};
      SFR_W789_OFS: r = {20'h0, bank.w[8], bank.w[7], bank.w[6]};
      default:      r = '0;
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sfr_apb_wait.sv
// sfr_apb_wait: APB access-phase wait-state counter; PREADY rises when the count reaches WAIT_STATES.
`default_nettype none

module sfr_apb_wait #(
  parameter int WAIT_STATES = 0
) (
  input  logic i_CLK,
  input  logic i_RST,
  input  logic psel_i,
  input  logic pen_i,
  output logic pready_o
);

  logic [3:0] cnt_q, cnt_d;

  assign pready_o = i_RST & psel_i & pen_i & (cnt_q == 4'(WAIT_STATES));

  always_comb begin
    cnt_d = cnt_q;
    if (!psel_i || pready_o)
      cnt_d = '0;
    else if (pen_i)
      cnt_d = cnt_q + 4'd1;
  end

  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

`default_nettype wire

// File: rtl/sfr_apb_shadow_regs.sv
// sfr_apb_shadow_regs: APB staging bank copied to the active bank on VSYNC rise.
// Optional macro SFR_FORCE_UPDATE_EN adds a write-only CTRL register at 0x34 for an immediate load.
`default_nettype none

module sfr_apb_shadow_regs
  import sfr_pkg::*;
#(
  parameter int WAIT_STATES = 0,
  parameter int ADDR_W      = 8
) (
  input  logic              i_CLK,
  input  logic              i_RST,
  input  logic              i_PSEL,
  input  logic              i_PEN,
  input  logic              i_PWRITE,
  input  logic [ADDR_W-1:0] i_PADDR,
  input  logic [31:0]       i_PWDATA,
  output logic [31:0]       o_PRDATA,
  output logic              o_PREADY,
  output logic              o_PSLVERR,
  input  logic              i_VSYNC,
  output logic [15:0]       o_vsw, o_vbp, o_vact, o_vfp,
  output logic [15:0]       o_hsw, o_hbp, o_hact, o_hfp,
  output logic              o_weight_wr_mode, o_mirror_mode, o_blur_mode,
  output logic [3:0]        o_w1, o_w2, o_w3, o_w4, o_w5, o_w6, o_w7, o_w8, o_w9
);

  sfr_bank_t   stg_q, stg_d, act_q, act_d;
  logic [7:0]  fcnt_q, fcnt_d;
  logic        pend_q, pend_d;
  logic        vs_prev_q;
  logic        force_q, force_d;

  logic        ready;
  logic        vs_edge, load, access, wr_bank, err;
  logic        hit_bank, hit_status, hit_ctrl;
  logic [7:0]  ofs;
  logic [31:0] rdata;

  sfr_apb_wait #(.WAIT_STATES(WAIT_STATES)) u_wait (
    .i_CLK    (i_CLK),
    .i_RST    (i_RST),
    .psel_i   (i_PSEL),
    .pen_i    (i_PEN),
    .pready_o (ready)
  );

  generate
    if (ADDR_W > 8) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^i_PADDR[ADDR_W-1:8];
    end
  endgenerate

  assign ofs        = i_PADDR[7:0];
  assign hit_bank   = sfr_is_bank_ofs(ofs);
  assign hit_status = (ofs == SFR_STATUS_OFS);
`ifdef SFR_FORCE_UPDATE_EN
  assign hit_ctrl   = (ofs == SFR_CTRL_OFS);
`else
  assign hit_ctrl   = 1'b0;
`endif

  assign err     = ~(hit_bank | hit_status | hit_ctrl) | (i_PWRITE & hit_status);
  assign access  = i_PSEL & i_PEN & ready;
  assign wr_bank = access & i_PWRITE & hit_bank;
  assign force_d = access & i_PWRITE & hit_ctrl & i_PWDATA[0];

  assign vs_edge = i_VSYNC & ~vs_prev_q;
  // A coinciding VSYNC edge and force load collapse into one copy
  assign load    = vs_edge | force_q;

  always_comb begin
    stg_d  = wr_bank ? sfr_apply_write(stg_q, ofs, i_PWDATA) : stg_q;
    act_d  = load ? stg_q : act_q;
    fcnt_d = vs_edge ? fcnt_q + 8'd1 : fcnt_q;
    pend_d = pend_q;
    if (wr_bank)
      pend_d = 1'b1;
    else if (load)
      pend_d = 1'b0;
  end

  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      stg_q     <= '0;
      act_q     <= '0;
      fcnt_q    <= '0;
      pend_q    <= 1'b0;
      vs_prev_q <= 1'b0;
      force_q   <= 1'b0;
    end else begin
      stg_q     <= stg_d;
      act_q     <= act_d;
      fcnt_q    <= fcnt_d;
      pend_q    <= pend_d;
      vs_prev_q <= i_VSYNC;
      force_q   <= force_d;
    end
  end

  always_comb begin
    rdata = '0;
    if (hit_bank)
      rdata = sfr_read_bank(stg_q, ofs);
    else if (hit_status)
      rdata = {16'h0, fcnt_q, 7'h0, pend_q};
  end

  assign o_PREADY  = ready;
  assign o_PSLVERR = ready & err;
  assign o_PRDATA  = (ready & ~i_PWRITE & ~err) ? rdata : 32'h0;

  assign o_vsw  = act_q.vsw;
  assign o_vbp  = act_q.vbp;
  assign o_vact = act_q.vact;
  assign o_vfp  = act_q.vfp;
  assign o_hsw  = act_q.hsw;
  assign o_hbp  = act_q.hbp;
  assign o_hact = act_q.hact;
  assign o_hfp  = act_q.hfp;

  assign o_weight_wr_mode = act_q.weight_wr_mode;
  assign o_mirror_mode    = act_q.mirror_mode;
  assign o_blur_mode      = act_q.blur_mode;

  assign o_w1 = act_q.w[0];
  assign o_w2 = act_q.w[1];
  assign o_w3 = act_q.w[2];
  assign o_w4 = act_q.w[3];
  assign o_w5 = act_q.w[4];
  assign o_w6 = act_q.w[5];
  assign o_w7 = act_q.w[6];
  assign o_w8 = act_q.w[7];
  assign o_w9 = act_q.w[8];

endmodule

`default_nettype wire

// File: tb/tb_sfr_apb_shadow_regs.sv
// tb_sfr_apb_shadow_regs: directed APB/VSYNC stimulus with a queue-based response scoreboard.
`default_nettype none

module tb_sfr_apb_shadow_regs;

  localparam int WS = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        psel, pen, pwrite, vsync;
  logic [7:0]  paddr;
  logic [31:0] pwdata;

  logic [31:0] o_PRDATA;
  logic        o_PREADY, o_PSLVERR;
  logic [15:0] o_vsw, o_vbp, o_vact, o_vfp, o_hsw, o_hbp, o_hact, o_hfp;
  logic        o_weight_wr_mode, o_mirror_mode, o_blur_mode;
  logic [3:0]  o_w1, o_w2, o_w3, o_w4, o_w5, o_w6, o_w7, o_w8, o_w9;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  sfr_apb_shadow_regs #(.WAIT_STATES(WS), .ADDR_W(8)) dut (
    .i_CLK(clk), .i_RST(rst),
    .i_PSEL(psel), .i_PEN(pen), .i_PWRITE(pwrite), .i_PADDR(paddr), .i_PWDATA(pwdata),
    .o_PRDATA(o_PRDATA), .o_PREADY(o_PREADY), .o_PSLVERR(o_PSLVERR),
    .i_VSYNC(vsync),
    .o_vsw(o_vsw), .o_vbp(o_vbp), .o_vact(o_vact), .o_vfp(o_vfp),
    .o_hsw(o_hsw), .o_hbp(o_hbp), .o_hact(o_hact), .o_hfp(o_hfp),
    .o_weight_wr_mode(o_weight_wr_mode), .o_mirror_mode(o_mirror_mode), .o_blur_mode(o_blur_mode),
    .o_w1(o_w1), .o_w2(o_w2), .o_w3(o_w3), .o_w4(o_w4), .o_w5(o_w5),
    .o_w6(o_w6), .o_w7(o_w7), .o_w8(o_w8), .o_w9(o_w9)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Issue one APB transfer; optionally raise VSYNC so its edge meets the commit edge.
  task automatic apb(input logic wr, input logic [7:0] a, input logic [31:0] wd,
                     input logic [31:0] exp_rd, input logic exp_err, input logic vs_commit);
    exp_t e;
    int   n;
    e.wr = wr; e.addr = a; e.data = exp_rd; e.err = exp_err;
    sb_q.push_back(e);
    @(posedge clk); #1;
    psel = 1'b1; pen = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
    @(posedge clk); #1;
    pen = 1'b1;
    n = 0;
    @(negedge clk);
    while (!o_PREADY && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk($sformatf("wait_states@%02h", a), n, WS);
    if (vs_commit) vsync = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; pen = 1'b0;
    if (vs_commit) vsync = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic exp_err);
    apb(1'b1, a, d, 32'h0, exp_err, 1'b0);
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] exp_d, input logic exp_err);
    apb(1'b0, a, 32'h0, exp_d, exp_err, 1'b0);
  endtask

  task automatic pulse_vsync();
    @(posedge clk); #1 vsync = 1'b1;
    @(posedge clk); #1 vsync = 1'b0;
  endtask

  // Monitor: pops and compares whenever the DUT completes an access
  always @(negedge clk) begin
    if (rst && psel && pen) begin
      if (o_PREADY) begin
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL apb_unexpected: PREADY with empty scoreboard addr 0x%02h", paddr);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          checks++;
          if (o_PSLVERR !== e.err || o_PRDATA !== e.data) begin
            errors++;
            $display("FAIL apb_%s@%02h: got prdata 0x%08h slverr %0b expected prdata 0x%08h slverr %0b",
                     e.wr ? "wr" : "rd", e.addr, o_PRDATA, o_PSLVERR, e.data, e.err);
          end
        end
      end else begin
        checks++;
        if (o_PRDATA !== 32'h0) begin
          errors++;
          $display("FAIL prdata_not_ready: got 0x%08h expected 0x00000000", o_PRDATA);
        end
      end
    end
  end

  initial begin
    rst = 1'b0; psel = 1'b0; pen = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0; vsync = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pready", {31'h0, o_PREADY}, 32'h0);
    chk("rst_pslverr", {31'h0, o_PSLVERR}, 32'h0);
    chk("rst_prdata", o_PRDATA, 32'h0);
    chk("rst_vtim", {o_vsw | o_vbp | o_vact | o_vfp, o_hsw | o_hbp | o_hact | o_hfp}, 32'h0);
    chk("rst_wmode", {o_w1, o_w2, o_w3, o_w4, o_w5, o_w6, o_w7, o_w8} | {28'h0, o_w9} |
                     {29'h0, o_blur_mode, o_mirror_mode, o_weight_wr_mode}, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    for (int a = 0; a <= 8'h30; a += 4) rd(8'(a), 32'h0, 1'b0);

    // Mid-frame writes stay in staging
    wr(8'h00, 32'h0000_0005, 1'b0);
    wr(8'h24, 32'h0000_0321, 1'b0);
    chk("vsw_before_vsync", {16'h0, o_vsw}, 32'h0);
    chk("w1_before_vsync", {28'h0, o_w1}, 32'h0);
    rd(8'h30, 32'h0000_0001, 1'b0);
    pulse_vsync();
    chk("vsw_after_vsync", {16'h0, o_vsw}, 32'h5);
    chk("w123_after_vsync", {20'h0, o_w3, o_w2, o_w1}, 32'h321);
    rd(8'h30, 32'h0000_0100, 1'b0);
    rd(8'h24, 32'h0000_0321, 1'b0);

    // Commit coinciding with VSYNC edge: active keeps old value
    apb(1'b1, 8'h18, 32'h0000_0780, 32'h0, 1'b0, 1'b1);
    @(posedge clk); #1;
    chk("hact_on_edge", {16'h0, o_hact}, 32'h0);
    rd(8'h30, 32'h0000_0201, 1'b0);
    rd(8'h18, 32'h0000_0780, 1'b0);
    pulse_vsync();
    chk("hact_next_vsync", {16'h0, o_hact}, 32'h780);
    rd(8'h30, 32'h0000_0300, 1'b0);

    // VSYNC held high counts once
    @(posedge clk); #1 vsync = 1'b1;
    repeat (6) @(posedge clk);
    #1 vsync = 1'b0;
    rd(8'h30, 32'h0000_0400, 1'b0);

    // Modes, weights and upper-bit truncation
    wr(8'h20, 32'h0000_0005, 1'b0);
    wr(8'h28, 32'hFFFF_F654, 1'b0);
    wr(8'h2C, 32'h0000_0987, 1'b0);
    wr(8'h04, 32'hABCD_1234, 1'b0);
    rd(8'h20, 32'h0000_0005, 1'b0);
    rd(8'h28, 32'h0000_0654, 1'b0);
    rd(8'h04, 32'h0000_1234, 1'b0);
    pulse_vsync();
    chk("modes", {29'h0, o_blur_mode, o_mirror_mode, o_weight_wr_mode}, 32'h5);
    chk("w4_w9", {8'h0, o_w4, o_w5, o_w6, o_w7, o_w8, o_w9}, 32'h0045_6789);
    chk("vbp", {16'h0, o_vbp}, 32'h1234);
    rd(8'h30, 32'h0000_0500, 1'b0);

    // Error responses leave state untouched
    wr(8'h30, 32'h0000_FFFF, 1'b1);
    wr(8'h40, 32'h0000_1111, 1'b1);
    rd(8'h40, 32'h0, 1'b1);
    rd(8'h02, 32'h0, 1'b1);
    wr(8'h01, 32'h0000_1234, 1'b1);
    rd(8'h00, 32'h0000_0005, 1'b0);
    rd(8'h30, 32'h0000_0500, 1'b0);

    // Force update
    wr(8'h1C, 32'h0000_0042, 1'b0);
`ifdef SFR_FORCE_UPDATE_EN
    wr(8'h34, 32'h0000_0001, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("hfp_forced", {16'h0, o_hfp}, 32'h42);
    rd(8'h30, 32'h0000_0500, 1'b0);
    rd(8'h34, 32'h0, 1'b0);
`else
    wr(8'h34, 32'h0000_0001, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("hfp_not_forced", {16'h0, o_hfp}, 32'h0);
    rd(8'h30, 32'h0000_0501, 1'b0);
    rd(8'h34, 32'h0, 1'b1);
`endif
    pulse_vsync();
    chk("hfp_vsync", {16'h0, o_hfp}, 32'h42);
    rd(8'h30, 32'h0000_0600, 1'b0);

    // frame_cnt wrap: 6 + 250 = 256 -> 0
    repeat (250) pulse_vsync();
    rd(8'h30, 32'h0000_0000, 1'b0);
    chk("vsw_stable", {16'h0, o_vsw}, 32'h5);

    repeat (2) @(posedge clk);
    chk("sb_empty", sb_q.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
